uart_rx_cfg: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8N1 receiver used by top-level command input. Adds configurable data width, parity mode and stop-bit count, and samples each bit with a 3-point majority vote. Reports parity errors, framing errors and break conditions. Sits between the board RX pin (via an internal synchroniser) and the command decoder in top.

---
 rtl/uart_rx_cfg.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Configurable UART receiver (5..9 data bits, none/odd/even
//                parity, 1 or 2 stop bits) with 3-point majority sampling,
//                parity/framing error flags and break detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    output logic                 rx_dv,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int c_half  = CLKS_PER_BIT / 2;
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

    localparam logic [c_cnt_w-1:0] c_samp_lo  = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_samp_mid = c_cnt_w'(c_half);
    localparam logic [c_cnt_w-1:0] c_decide   = c_cnt_w'(c_half + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         c_last_dat = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_last_stp = 4'(STOP_BITS - 1);
    localparam logic               c_par_en   = (PARITY != 0);
    localparam logic               c_par_odd  = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_START      = 3'd1,
        S_DATA       = 3'd2,
        S_PARITY     = 3'd3,
        S_STOP       = 3'd4,
        S_BREAK_WAIT = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic [c_cnt_w-1:0]     r_clk_cnt;
    logic [3:0]             r_bit_idx;
    logic                   r_s_lo;
    logic                   r_s_mid;
    logic                   w_maj;
    logic                   w_decide;
    logic                   w_bit_end;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_zero;
    logic                   w_par_exp;
    logic                   w_emit;
    logic                   w_brk;
    logic                   r_dv;
    logic [DATA_BITS-1:0]   r_byte;
    logic                   r_parity_err;
    logic                   r_frame_err;
    logic                   r_break_det;

    // Bring the asynchronous pin into the clock domain; idle level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign w_rxs     = r_sync[SYNC_STAGES-1];
    // Third sample is the live value at the decision point.
    assign w_maj     = (r_s_lo & r_s_mid) | (r_s_lo & w_rxs) | (r_s_mid & w_rxs);
    assign w_decide  = (r_clk_cnt == c_decide);
    assign w_bit_end = (r_clk_cnt == c_last_cnt);
    assign w_par_exp = c_par_odd ? ~(^r_shift) : (^r_shift);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus the end-of-frame strobe and break qualifier.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_brk       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_decide && w_maj) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == c_last_dat)) begin
                    w_state_nxt = c_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Return early at the last stop decision so a following
                // start edge can be caught without losing half a bit.
                if (w_decide && (r_bit_idx == c_last_stp)) begin
                    w_emit      = 1'b1;
                    w_brk       = r_zero & ~w_maj;
                    w_state_nxt = w_brk ? S_BREAK_WAIT : S_IDLE;
                end
            end
            S_BREAK_WAIT: begin
                if (w_rxs && w_bit_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit timing: in-bit clock counter, bit index and the two early samples.
    // In BREAK_WAIT the counter instead counts consecutive idle-high clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_s_lo    <= 1'b1;
            r_s_mid   <= 1'b1;
        end else begin
            if ((r_state == S_IDLE) || (w_state_nxt == S_IDLE)) begin
                r_clk_cnt <= '0;
            end else if (r_state == S_BREAK_WAIT) begin
                r_clk_cnt <= w_rxs ? (r_clk_cnt + c_cnt_w'(1)) : '0;
            end else if (w_state_nxt == S_BREAK_WAIT) begin
                r_clk_cnt <= '0;
            end else if (w_bit_end) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + c_cnt_w'(1);
            end

            if (r_state != w_state_nxt) begin
                r_bit_idx <= '0;
            end else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP))) begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end

            if (r_clk_cnt == c_samp_lo) begin
                r_s_lo <= w_rxs;
            end
            if (r_clk_cnt == c_samp_mid) begin
                r_s_mid <= w_rxs;
            end
        end
    end

    // Frame accumulation: data shift register and per-frame error tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_zero  <= 1'b1;
        end else if (r_state == S_IDLE) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_zero <= 1'b1;
        end else if (w_decide) begin
            case (r_state)
                S_DATA: begin
                    r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    r_zero  <= r_zero & ~w_maj;
                end
                S_PARITY: begin
                    r_perr <= (w_maj != w_par_exp);
                    r_zero <= r_zero & ~w_maj;
                end
                S_STOP: begin
                    r_ferr <= r_ferr | ~w_maj;
                    r_zero <= r_zero & ~w_maj;
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers: only change in the frame-complete cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dv         <= 1'b0;
            r_byte       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_det  <= 1'b0;
        end else begin
            r_dv        <= w_emit;
            r_break_det <= w_emit & w_brk;
            if (w_emit) begin
                r_byte       <= w_brk ? '0 : r_shift;
                r_parity_err <= r_perr;
                r_frame_err  <= r_ferr | ~w_maj;
            end
        end
    end

    assign rx_dv      = r_dv;
    assign rx_byte    = r_byte;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign break_det  = r_break_det;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Directed self-checking bench for uart_rx_cfg: 8N1, 8E1 and
//                8N2 instances, each on its own serial line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int CPB  = 87;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx    [3];
    logic       dv    [3];
    logic [7:0] dbyte [3];
    logic       pe    [3];
    logic       fe    [3];
    logic       brk   [3];
    logic       bsy   [3];

    int checks   = 0;
    int failures = 0;

    int         dv_cnt  [3];
    int         brk_cnt [3];
    logic [7:0] h_byte  [3][64];
    logic       h_pe    [3][64];
    logic       h_fe    [3][64];
    logic       h_brk   [3][64];

    always #5 clk = ~clk;

    // 8N1 defaults
    uart_rx_cfg #(.CLKS_PER_BIT(CPB)) u_8n1 (
        .clk(clk), .reset(reset), .rx_serial(rx[0]), .rx_dv(dv[0]), .rx_byte(dbyte[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .break_det(brk[0]), .busy(bsy[0]));

    // 8E1
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_8e1 (
        .clk(clk), .reset(reset), .rx_serial(rx[1]), .rx_dv(dv[1]), .rx_byte(dbyte[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .break_det(brk[1]), .busy(bsy[1]));

    // 8N2
    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .rx_serial(rx[2]), .rx_dv(dv[2]), .rx_byte(dbyte[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .break_det(brk[2]), .busy(bsy[2]));

    // Record every completed frame per receiver, sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (brk[i] === 1'b1) brk_cnt[i] = brk_cnt[i] + 1;
            if (dv[i] === 1'b1) begin
                if (dv_cnt[i] < 64) begin
                    h_byte[i][dv_cnt[i]] = dbyte[i];
                    h_pe[i][dv_cnt[i]]   = pe[i];
                    h_fe[i][dv_cnt[i]]   = fe[i];
                    h_brk[i][dv_cnt[i]]  = brk[i];
                end
                dv_cnt[i] = dv_cnt[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Frame bits LSB first: start 0, data, then tail bits (parity/stops).
    function automatic logic [15:0] mk(input logic [7:0] d, input logic [2:0] tail);
        return {4'b1111, tail, d, 1'b0};
    endfunction

    // Drive nbits frame bits of CPB clocks each; glitch inverts one clock.
    task automatic send(input int sel, input logic [15:0] bits, input int nbits, input int glitch);
        logic b;
        for (int k = 0; k < nbits * CPB; k++) begin
            @(negedge clk);
            b = bits[k / CPB];
            rx[sel] = b ^ (k == glitch);
        end
        @(negedge clk);
        rx[sel] = 1'b1;
    endtask

    int         base;
    int         bbase;
    logic [15:0] fr;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx[i] = 1'b1; dv_cnt[i] = 0; brk_cnt[i] = 0;
        end
        reset = 1'b1;
        idle(3);
        chk("rst_dv",   32'(dv[0]),    32'h0);
        chk("rst_byte", 32'(dbyte[0]), 32'h0);
        chk("rst_pe",   32'(pe[0]),    32'h0);
        chk("rst_fe",   32'(fe[0]),    32'h0);
        chk("rst_brk",  32'(brk[0]),   32'h0);
        chk("rst_busy", 32'(bsy[0]),   32'h0);
        reset = 1'b0;
        idle(5);

        // 8N1: 0x3F
        base = dv_cnt[0]; bbase = brk_cnt[0];
        send(0, mk(8'h3F, 3'b111), 10, -1);
        idle(2 * CPB);
        chk("n1_dv_count", 32'(dv_cnt[0] - base), 32'd1);
        chk("n1_byte",     32'(h_byte[0][base]),  32'h3F);
        chk("n1_pe",       32'(h_pe[0][base]),    32'h0);
        chk("n1_fe",       32'(h_fe[0][base]),    32'h0);
        chk("n1_brk",      32'(brk_cnt[0] - bbase), 32'd0);
        chk("n1_busy",     32'(bsy[0]),           32'h0);

        // False start: 20 clocks low
        base = dv_cnt[0];
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rx[0] = 1'b0;
            if (k == 15) chk("glitch_busy_hi", 32'(bsy[0]), 32'h1);
        end
        @(negedge clk); rx[0] = 1'b1;
        idle(2 * CPB);
        chk("glitch_no_dv",  32'(dv_cnt[0] - base), 32'd0);
        chk("glitch_busy_lo", 32'(bsy[0]),          32'h0);

        // One-clock inversion on data bit 3 (frame bit 4), placed so that the
        // synchronised line carries it at the mid (H) sample point.
        base = dv_cnt[0];
        send(0, mk(8'h3F, 3'b111), 10, 1 + 4 * CPB + HALF);
        idle(2 * CPB);
        chk("maj_dv_count", 32'(dv_cnt[0] - base), 32'd1);
        chk("maj_byte",     32'(h_byte[0][base]),  32'h3F);

        // Break: 12 bit times low, 2 high, then 0xC3
        base = dv_cnt[0]; bbase = brk_cnt[0];
        for (int k = 0; k < 12 * CPB; k++) begin @(negedge clk); rx[0] = 1'b0; end
        for (int k = 0; k < 2 * CPB; k++)  begin @(negedge clk); rx[0] = 1'b1; end
        send(0, mk(8'hC3, 3'b111), 10, -1);
        idle(2 * CPB);
        chk("brk_dv_count",  32'(dv_cnt[0] - base),   32'd2);
        chk("brk_det_count", 32'(brk_cnt[0] - bbase), 32'd1);
        chk("brk_byte",      32'(h_byte[0][base]),    32'h00);
        chk("brk_fe",        32'(h_fe[0][base]),      32'h1);
        chk("brk_flag",      32'(h_brk[0][base]),     32'h1);
        chk("post_brk_byte", 32'(h_byte[0][base+1]),  32'hC3);
        chk("post_brk_fe",   32'(h_fe[0][base+1]),    32'h0);
        chk("post_brk_flag", 32'(h_brk[0][base+1]),   32'h0);

        // 8E1: 0xA5 (4 ones) with correct parity 0, then wrong parity 1
        base = dv_cnt[1];
        send(1, mk(8'hA5, 3'b110), 11, -1);
        idle(2 * CPB);
        send(1, mk(8'hA5, 3'b111), 11, -1);
        idle(2 * CPB);
        chk("e1_dv_count", 32'(dv_cnt[1] - base),  32'd2);
        chk("e1_ok_byte",  32'(h_byte[1][base]),   32'hA5);
        chk("e1_ok_pe",    32'(h_pe[1][base]),     32'h0);
        chk("e1_ok_fe",    32'(h_fe[1][base]),     32'h0);
        chk("e1_bad_byte", 32'(h_byte[1][base+1]), 32'hA5);
        chk("e1_bad_pe",   32'(h_pe[1][base+1]),   32'h1);
        chk("e1_hold_pe",  32'(pe[1]),             32'h1);

        // 8N2: 0x55 with second stop bit 0, then 0x0F with good stops
        base = dv_cnt[2];
        send(2, mk(8'h55, 3'b101), 11, -1);
        idle(2 * CPB);
        send(2, mk(8'h0F, 3'b111), 11, -1);
        idle(2 * CPB);
        chk("n2_dv_count", 32'(dv_cnt[2] - base),  32'd2);
        chk("n2_bad_byte", 32'(h_byte[2][base]),   32'h55);
        chk("n2_bad_fe",   32'(h_fe[2][base]),     32'h1);
        chk("n2_ok_byte",  32'(h_byte[2][base+1]), 32'h0F);
        chk("n2_ok_fe",    32'(h_fe[2][base+1]),   32'h0);

        // Reset in the middle of data bit 4 of 0xAB; sender then abandons it.
        base = dv_cnt[0];
        fr = mk(8'hAB, 3'b111);
        for (int k = 0; k < 5 * CPB + 40; k++) begin
            @(negedge clk);
            rx[0] = fr[k / CPB];
        end
        chk("mid_busy_hi", 32'(bsy[0]), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_dv",    32'(dv[0]),    32'h0);
        chk("mrst_byte",  32'(dbyte[0]), 32'h0);
        chk("mrst_fe",    32'(fe[0]),    32'h0);
        chk("mrst_brk",   32'(brk[0]),   32'h0);
        chk("mrst_busy",  32'(bsy[0]),   32'h0);
        chk("mrst_byte1", 32'(dbyte[1]), 32'h0);
        chk("mrst_pe1",   32'(pe[1]),    32'h0);
        rx[0] = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(3 * CPB);
        chk("mrst_no_dv", 32'(dv_cnt[0] - base), 32'd0);
        send(0, mk(8'h12, 3'b111), 10, -1);
        idle(2 * CPB);
        chk("mrst_dv_count", 32'(dv_cnt[0] - base), 32'd1);
        chk("mrst_next_byte", 32'(h_byte[0][base]), 32'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
